// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port synchronous RAM.
// Define RAM_ARB_RR_EN for round-robin arbitration; default is fixed priority (port 0 wins).
module ram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ready,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ready,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_read,
    output logic                  ram_write,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    logic grant0, grant1;
    logic accept;
    cmd_t sel_cmd;
    logic cmd_owner;
    logic rd_pend;
    logic rd_owner;

`ifdef RAM_ARB_RR_EN
    // last = index of the most recently accepted port; reset to 1 so port 0 wins first.
    logic last;

    always_comb begin
        grant0 = m0_req & (~m1_req | last);
        grant1 = m1_req & (~m0_req | ~last);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            last <= 1'b1;
        else if (accept)
            last <= m1_ready;
    end
`else
    always_comb begin
        grant0 = m0_req;
        grant1 = m1_req & ~m0_req;
    end
`endif

    // Grants are suppressed while reset is asserted so nothing is accepted.
    assign m0_ready = grant0 & rst_n;
    assign m1_ready = grant1 & rst_n;
    assign accept   = m0_ready | m1_ready;

    always_comb begin
        if (m1_ready)
            sel_cmd = '{we: m1_we, addr: m1_addr, wdata: m1_wdata};
        else
            sel_cmd = '{we: m0_we, addr: m0_addr, wdata: m0_wdata};
    end

    // Stage 1: command register driving the RAM pins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_addr    <= '0;
            ram_data_in <= '0;
            ram_read    <= 1'b0;
            ram_write   <= 1'b0;
            cmd_owner   <= 1'b0;
        end else if (accept) begin
            ram_addr    <= sel_cmd.addr;
            ram_data_in <= sel_cmd.wdata;
            ram_read    <= ~sel_cmd.we;
            ram_write   <= sel_cmd.we;
            cmd_owner   <= m1_ready;
        end else begin
            ram_read    <= 1'b0;
            ram_write   <= 1'b0;
        end
    end

    // Stage 2: tag that follows the RAM's one-cycle read latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            rd_pend  <= ram_read;
            rd_owner <= cmd_owner;
        end
    end

    assign m0_rvalid = rd_pend & ~rd_owner;
    assign m1_rvalid = rd_pend &  rd_owner;
    assign m0_rdata  = ram_data_out;
    assign m1_rdata  = ram_data_out;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed table-driven bench for ram_arbiter with a behavioural RAM model attached.
module tb_ram_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_ready, m0_rvalid, m1_ready, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data_in, ram_data_out;
    logic          ram_read, ram_write;

    int checks = 0;
    int errors = 0;

    ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_read(ram_read),
        .ram_write(ram_write), .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // Single-port RAM: registered write, registered read.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    initial ram_data_out = '0;
    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_data_in;
        if (ram_read)  ram_data_out  <= mem[ram_addr];
    end

    typedef struct {
        logic q0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
        logic q1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
        logic e_r0, e_r1, e_v0, e_v1; logic [DW-1:0] e_d;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic q0, logic w0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                                logic q1, logic w1, logic [AW-1:0] a1, logic [DW-1:0] d1,
                                logic r0, logic r1, logic v0, logic v1, logic [DW-1:0] ed);
        vec_t v;
        v.q0 = q0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.q1 = q1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.e_r0 = r0; v.e_r1 = r1; v.e_v0 = v0; v.e_v1 = v1; v.e_d = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic q0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic q1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        m0_req = q0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = q1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    endtask

    initial begin
        vec_t nop;
        nop = mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0);

        // Write then read addr 3 on port 0; write produces no response.
        vt.push_back(mk(1,1,3,32'hDEADBEEF, 0,0,0,0, 1,0,0,0,0));
        vt.push_back(mk(1,0,3,0,            0,0,0,0, 1,0,0,0,0));
        vt.push_back(nop);
        vt.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,1,0,32'hDEADBEEF));
        // Preload addr 1/2 from different ports.
        vt.push_back(mk(1,1,1,32'h11, 0,0,0,0,      1,0,0,0,0));
        vt.push_back(mk(0,0,0,0,      1,1,2,32'h22, 0,1,0,0,0));
        // Six cycles of contention.
        for (int k = 0; k < 6; k++) begin
`ifdef RAM_ARB_RR_EN
            vt.push_back(mk(1,0,1,0, 1,0,2,0, (k%2)==0, (k%2)==1,
                            k>=2 && (k%2)==0, k>=2 && (k%2)==1,
                            (k%2)==0 ? 32'h11 : 32'h22));
`else
            vt.push_back(mk(1,0,1,0, 1,0,2,0, 1, 0, k>=2, 0, 32'h11));
`endif
        end
        // Port 0 drops; port 1 granted on the next cycle.
`ifdef RAM_ARB_RR_EN
        vt.push_back(mk(0,0,0,0, 1,0,2,0, 0,1,1,0,32'h11));
        vt.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,1,32'h22));
`else
        vt.push_back(mk(0,0,0,0, 1,0,2,0, 0,1,1,0,32'h11));
        vt.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,1,0,32'h11));
`endif
        vt.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,1,32'h22));
        // Write on port 1 immediately followed by read on port 0 of the same address.
        vt.push_back(mk(0,0,0,0, 1,1,7,32'h5, 0,1,0,0,0));
        vt.push_back(mk(1,0,7,0, 0,0,0,0,     1,0,0,0,0));
        vt.push_back(nop);
        vt.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,1,0,32'h5));
        // Address extremes, read back from both ports.
        vt.push_back(mk(1,1,0,32'hA5A5A5A5, 0,0,0,0, 1,0,0,0,0));
        vt.push_back(mk(0,0,0,0, 1,1,31,32'h5A5A5A5A, 0,1,0,0,0));
        vt.push_back(mk(1,0,31,0, 0,0,0,0, 1,0,0,0,0));
        vt.push_back(mk(0,0,0,0, 1,0,0,0,  0,1,0,0,0));
        vt.push_back(mk(1,0,0,0, 0,0,0,0,  1,0,1,0,32'h5A5A5A5A));
        vt.push_back(mk(0,0,0,0, 1,0,31,0, 0,1,0,1,32'hA5A5A5A5));
        vt.push_back(mk(0,0,0,0, 0,0,0,0,  0,0,1,0,32'hA5A5A5A5));
        vt.push_back(mk(0,0,0,0, 0,0,0,0,  0,0,0,1,32'h5A5A5A5A));

        // Reset with requests asserted: no grants, pins cleared.
        rst_n = 1'b0;
        drive(1,0,4,0, 1,1,5,32'h77);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst m0_ready", m0_ready, 0);
        chk("rst m1_ready", m1_ready, 0);
        chk("rst ram_read", ram_read, 0);
        chk("rst ram_write", ram_write, 0);
        chk("rst rvalid", {m0_rvalid, m1_rvalid}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(0,0,0,0, 0,0,0,0);

        foreach (vt[i]) begin
            @(posedge clk); #1;
            drive(vt[i].q0, vt[i].w0, vt[i].a0, vt[i].d0, vt[i].q1, vt[i].w1, vt[i].a1, vt[i].d1);
            @(negedge clk);
            chk($sformatf("v%0d m0_ready", i), m0_ready, vt[i].e_r0);
            chk($sformatf("v%0d m1_ready", i), m1_ready, vt[i].e_r1);
            chk($sformatf("v%0d m0_rvalid", i), m0_rvalid, vt[i].e_v0);
            chk($sformatf("v%0d m1_rvalid", i), m1_rvalid, vt[i].e_v1);
            if (vt[i].e_v0) chk($sformatf("v%0d m0_rdata", i), m0_rdata, vt[i].e_d);
            if (vt[i].e_v1) chk($sformatf("v%0d m1_rdata", i), m1_rdata, vt[i].e_d);
        end

        // Command register contents, then hold of addr/data when idle.
        @(posedge clk); #1;
        drive(0,0,0,0, 1,1,9,32'h1234);
        @(posedge clk); #1;
        drive(0,0,0,0, 0,0,0,0);
        @(negedge clk);
        chk("cmd ram_write", ram_write, 1);
        chk("cmd ram_read", ram_read, 0);
        chk("cmd ram_addr", ram_addr, 9);
        chk("cmd ram_data_in", ram_data_in, 32'h1234);
        @(posedge clk); @(negedge clk);
        chk("idle ram_write", ram_write, 0);
        chk("idle ram_addr hold", ram_addr, 9);
        chk("idle ram_data_in hold", ram_data_in, 32'h1234);

        // Read accepted, then reset on the next edge: response is discarded.
        @(posedge clk); #1;
        drive(1,0,3,0, 0,0,0,0);
        @(negedge clk);
        chk("mid m0_ready", m0_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(0,0,0,0, 0,0,0,0);
        @(negedge clk);
        chk("mid pins ram_read", ram_read, 1);
        @(posedge clk); @(negedge clk);
        chk("mid ram_read", ram_read, 0);
        chk("mid ram_write", ram_write, 0);
        chk("mid ram_addr", ram_addr, 0);
        chk("mid ram_data_in", ram_data_in, 0);
        chk("mid rvalid", {m0_rvalid, m1_rvalid}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post rst rvalid %0d", k), {m0_rvalid, m1_rvalid}, 0);
        end

        // First contention after reset goes to port 0; then RR hands the next to port 1.
        @(posedge clk); #1;
        drive(1,0,1,0, 1,0,2,0);
        @(negedge clk);
        chk("first m0_ready", m0_ready, 1);
        chk("first m1_ready", m1_ready, 0);
        @(posedge clk); @(negedge clk);
`ifdef RAM_ARB_RR_EN
        chk("second m1_ready", m1_ready, 1);
        chk("second m0_ready", m0_ready, 0);
`else
        chk("second m1_ready", m1_ready, 0);
        chk("second m0_ready", m0_ready, 1);
`endif
        @(posedge clk); #1;
        drive(0,0,0,0, 0,0,0,0);
        @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
